// File: rtl/sp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sp_pkg
// Brief    : Shared types and constants for the solar-panel scan sequencer:
//            FSM state encoding, axis identifiers, default timing values and
//            a helper that checks whether a sweep step still fits the range.
// Revision : 1.0 - initial release
// ============================================================================
package sp_pkg;

    localparam int unsigned c_pos_w  = 32;
    localparam int unsigned c_adc_w  = 12;
    localparam int unsigned c_stat_w = 3;

    typedef enum logic [c_stat_w-1:0] {
        ST_IDLE   = 3'd0,
        ST_SETTLE = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_EVAL   = 3'd3,
        ST_PARK   = 3'd4,
        ST_FIN    = 3'd5
    } state_e;

    typedef enum logic {
        AXIS_H = 1'b0,
        AXIS_V = 1'b1
    } axis_e;

    localparam logic [c_pos_w-1:0] c_pos_min_default    = 32'd100000;
    localparam logic [c_pos_w-1:0] c_pos_max_default    = 32'd200000;
    localparam logic [c_pos_w-1:0] c_pos_step_default   = 32'd10000;
    localparam logic [c_pos_w-1:0] c_pos_rst_default    = 32'd150000;
    localparam logic [c_pos_w-1:0] c_settle_cyc_default = 32'd2000000;

    // Next position computed one bit wider so a step near the top of the
    // 32-bit range cannot wrap and look like it still fits.
    function automatic logic step_fits(input logic [c_pos_w-1:0] pos,
                                       input logic [c_pos_w-1:0] step,
                                       input logic [c_pos_w-1:0] pos_max);
        logic [c_pos_w:0] nxt;
        nxt = {1'b0, pos} + {1'b0, step};
        return (nxt <= {1'b0, pos_max});
    endfunction

endpackage
`default_nettype wire

// File: rtl/sp_scan_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : sp_scan_sequencer_if
// Brief    : Control, ADC handshake and servo/status bundle of the scan
//            sequencer. "slave" is the sequencer side, "master" the
//            controller/ADC side that drives START/ABORT and the ADC reply.
// Revision : 1.0 - initial release
// ============================================================================
interface sp_scan_sequencer_if;
    import sp_pkg::*;

    logic                  start;
    logic                  abort;
    logic                  adc_req;
    logic                  adc_ack;
    logic [c_adc_w-1:0]    adc_data;
    logic [c_pos_w-1:0]    pos_h;
    logic [c_pos_w-1:0]    pos_v;
    logic [c_adc_w-1:0]    max_v;
    logic                  busy;
    logic                  done;
    logic [c_stat_w-1:0]   stat;

    modport master (
        output start, abort, adc_ack, adc_data,
        input  adc_req, pos_h, pos_v, max_v, busy, done, stat
    );

    modport slave (
        input  start, abort, adc_ack, adc_data,
        output adc_req, pos_h, pos_v, max_v, busy, done, stat
    );

endinterface
`default_nettype wire

// File: rtl/sp_settle_timer.sv
`default_nettype none
// ============================================================================
// Module   : sp_settle_timer
// Brief    : 32-bit settle countdown. load presets the count, count
//            decrements it, expire flags the last cycle of the wait.
// Revision : 1.0 - initial release
// ============================================================================
module sp_settle_timer (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        load,
    input  wire logic [31:0] load_val,
    input  wire logic        count,
    output logic             expire
);

    logic [31:0] r_count;

    // Countdown register: load wins over count, stops at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (count && (r_count != 32'd0)) begin
            r_count <= r_count - 32'd1;
        end
    end

    // A wait of N cycles loaded with N ends in the cycle the count reads 1.
    assign expire = (r_count == 32'd1);

endmodule
`default_nettype wire

// File: rtl/sp_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sp_scan_sequencer
// Brief    : Two-axis servo sweep: steps each axis from POS_MIN to POS_MAX,
//            samples the panel voltage at every stop, parks the axis at the
//            best position and reports the best sample on MAX_V.
// Revision : 1.0 - initial release
// ============================================================================
module sp_scan_sequencer
    import sp_pkg::*;
#(
    parameter logic [31:0] POS_MIN       = c_pos_min_default,
    parameter logic [31:0] POS_MAX       = c_pos_max_default,
    parameter logic [31:0] POS_STEP      = c_pos_step_default,
    parameter logic [31:0] POS_RST       = c_pos_rst_default,
    parameter logic [31:0] SETTLE_CYCLES = c_settle_cyc_default
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    sp_scan_sequencer_if.slave bus
);

    state_e               r_state;
    state_e               w_state_nxt;
    axis_e                r_axis;
    logic [c_pos_w-1:0]   r_pos_h;
    logic [c_pos_w-1:0]   r_pos_v;
    logic [c_adc_w-1:0]   r_max_v;
    logic [c_adc_w-1:0]   r_best;
    logic [c_pos_w-1:0]   r_best_pos;
    logic [c_adc_w-1:0]   r_sample;
    logic                 r_adc_req;

    logic                 w_tmr_load;
    logic                 w_tmr_count;
    logic                 w_tmr_expire;
    logic [c_pos_w-1:0]   w_pos_act;
    logic                 w_step_fits;
    logic                 w_take;
    logic [c_adc_w-1:0]   w_best_nxt;
    logic [c_pos_w-1:0]   w_best_pos_nxt;

    sp_settle_timer u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (w_tmr_load),
        .load_val (SETTLE_CYCLES),
        .count    (w_tmr_count),
        .expire   (w_tmr_expire)
    );

    // Sweep arithmetic on the active axis; ties keep the earlier position.
    assign w_pos_act      = (r_axis == AXIS_H) ? r_pos_h : r_pos_v;
    assign w_step_fits    = step_fits(w_pos_act, POS_STEP, POS_MAX);
    assign w_take         = (r_sample > r_best);
    assign w_best_nxt     = w_take ? r_sample  : r_best;
    assign w_best_pos_nxt = w_take ? w_pos_act : r_best_pos;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and timer control; abort overrides every transition.
    always_comb begin
        w_state_nxt = r_state;
        w_tmr_load  = 1'b0;
        w_tmr_count = 1'b0;
        if (bus.abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        w_state_nxt = ST_SETTLE;
                        w_tmr_load  = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    w_tmr_count = 1'b1;
                    if (w_tmr_expire) begin
                        w_state_nxt = ST_SAMPLE;
                    end
                end
                ST_SAMPLE: begin
                    if (bus.adc_ack) begin
                        w_state_nxt = ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    w_tmr_load  = 1'b1;
                    w_state_nxt = w_step_fits ? ST_SETTLE : ST_PARK;
                end
                ST_PARK: begin
                    w_tmr_count = 1'b1;
                    if (w_tmr_expire) begin
                        w_state_nxt = (r_axis == AXIS_H) ? ST_SETTLE : ST_FIN;
                        w_tmr_load  = (r_axis == AXIS_H);
                    end
                end
                ST_FIN: begin
                    w_state_nxt = ST_IDLE;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // Datapath: positions, best tracking, sample capture and ADC request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_axis     <= AXIS_H;
            r_pos_h    <= POS_RST;
            r_pos_v    <= POS_RST;
            r_max_v    <= '0;
            r_best     <= '0;
            r_best_pos <= POS_MIN;
            r_sample   <= '0;
            r_adc_req  <= 1'b0;
        end else if (bus.abort) begin
            r_adc_req <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_axis     <= AXIS_H;
                        r_pos_h    <= POS_MIN;
                        r_best     <= '0;
                        r_best_pos <= POS_MIN;
                    end
                end
                ST_SETTLE: begin
                    if (w_tmr_expire) begin
                        r_adc_req <= 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (bus.adc_ack) begin
                        r_sample  <= bus.adc_data;
                        r_adc_req <= 1'b0;
                    end
                end
                ST_EVAL: begin
                    r_best     <= w_best_nxt;
                    r_best_pos <= w_best_pos_nxt;
                    if (w_step_fits) begin
                        if (r_axis == AXIS_H) r_pos_h <= w_pos_act + POS_STEP;
                        else                  r_pos_v <= w_pos_act + POS_STEP;
                    end else begin
                        // Entering PARK: move to the best stop, publish its sample.
                        if (r_axis == AXIS_H) r_pos_h <= w_best_pos_nxt;
                        else                  r_pos_v <= w_best_pos_nxt;
                        r_max_v <= w_best_nxt;
                    end
                end
                ST_PARK: begin
                    if (w_tmr_expire && (r_axis == AXIS_H)) begin
                        r_axis     <= AXIS_V;
                        r_pos_v    <= POS_MIN;
                        r_best     <= '0;
                        r_best_pos <= POS_MIN;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.adc_req = r_adc_req;
    assign bus.pos_h   = r_pos_h;
    assign bus.pos_v   = r_pos_v;
    assign bus.max_v   = r_max_v;
    assign bus.busy    = (r_state != ST_IDLE);
    assign bus.done    = (r_state == ST_FIN);
    assign bus.stat    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_sp_scan_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sp_scan_sequencer
// Brief    : Directed bench for sp_scan_sequencer with an ADC responder and a
//            scoreboard of expected servo positions per ADC transaction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sp_scan_sequencer;

    typedef struct packed {
        logic [31:0] h;
        logic [31:0] v;
    } exp_t;

    logic clk;
    logic rst_n;

    sp_scan_sequencer_if bus ();

    sp_scan_sequencer #(
        .POS_MIN       (32'd100),
        .POS_MAX       (32'd140),
        .POS_STEP      (32'd10),
        .POS_RST       (32'd120),
        .SETTLE_CYCLES (32'd3)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    int          txn_cnt = 0;
    int          done_cnt = 0;
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          idle_ack_cnt = 0;
    int          idle_ack_done = 0;
    int          run_settle = 0;
    int          run_park = 0;
    logic [2:0]  prev_stat = 3'd0;
    logic [11:0] smp_q[$];
    exp_t        exp_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ADC responder: acks ack_delay cycles after seeing REQ, pops the next
    // sample and checks the servo positions against the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (bus.adc_ack) begin
            bus.adc_ack = 1'b0;
        end else if (bus.adc_req) begin
            if (wait_cnt >= ack_delay) begin
                wait_cnt = 0;
                bus.adc_ack = 1'b1;
                check("smp_avail", 32'(smp_q.size() != 0), 32'd1);
                bus.adc_data = (smp_q.size() != 0) ? smp_q.pop_front() : 12'd0;
                check("exp_avail", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("txn_pos_h", bus.pos_h, e.h);
                    check("txn_pos_v", bus.pos_v, e.v);
                end
                txn_cnt++;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
            if (idle_ack_cnt != idle_ack_done) begin
                bus.adc_ack  = 1'b1;
                bus.adc_data = 12'hFFF;
                idle_ack_done++;
            end
        end
    end

    // Monitor: DONE pulses and the length of every SETTLE and PARK wait.
    always @(negedge clk) begin
        if (!rst_n) begin
            run_settle = 0;
            run_park   = 0;
            prev_stat  = 3'd0;
        end else begin
            if (bus.done) done_cnt++;
            if (bus.stat == 3'd1) begin
                run_settle++;
            end else begin
                if (prev_stat == 3'd1 && bus.stat == 3'd2) check("settle_len", run_settle, 32'd3);
                run_settle = 0;
            end
            if (bus.stat == 3'd4) begin
                run_park++;
            end else begin
                if (prev_stat == 3'd4 && bus.stat != 3'd0) check("park_len", run_park, 32'd3);
                run_park = 0;
            end
            prev_stat = bus.stat;
        end
    end

    task automatic pulse_start();
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_stat(input logic [2:0] s, input int bound, input string tag);
        int n = 0;
        while (bus.stat !== s && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(tag, bus.stat, s);
    endtask

    task automatic push_sweep(input logic [11:0] s0, s1, s2, s3, s4,
                              input logic axis_v, input logic [31:0] other);
        logic [11:0] s[5];
        s = '{s0, s1, s2, s3, s4};
        for (int i = 0; i < 5; i++) begin
            exp_t e;
            smp_q.push_back(s[i]);
            e.h = axis_v ? other : 32'(100 + 10 * i);
            e.v = axis_v ? 32'(100 + 10 * i) : other;
            exp_q.push_back(e);
        end
    endtask

    initial begin
        int d0;
        int t0;
        int n;
        exp_t e;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.adc_ack  = 1'b0;
        bus.adc_data = 12'd0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Reset state after idle cycles.
        check("rst_pos_h",   bus.pos_h,   32'd120);
        check("rst_pos_v",   bus.pos_v,   32'd120);
        check("rst_max_v",   bus.max_v,   32'd0);
        check("rst_stat",    bus.stat,    32'd0);
        check("rst_busy",    bus.busy,    32'd0);
        check("rst_adc_req", bus.adc_req, 32'd0);
        check("rst_done",    bus.done,    32'd0);

        // Full scan; a second START mid-scan must be ignored.
        push_sweep(12'd5, 12'd9, 12'd30, 12'd30, 12'd2, 1'b0, 32'd120);
        push_sweep(12'd40, 12'd1, 12'd1, 12'd1, 12'd50, 1'b1, 32'd120);
        d0 = done_cnt;
        pulse_start();
        repeat (6) @(negedge clk);
        pulse_start();
        n = 0;
        while (done_cnt == d0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        check("scan_done_cnt", done_cnt, d0 + 1);
        check("scan_pos_h",    bus.pos_h, 32'd120);
        check("scan_pos_v",    bus.pos_v, 32'd140);
        check("scan_max_v",    bus.max_v, 32'd50);
        check("scan_txn",      txn_cnt,   32'd10);
        check("scan_busy",     bus.busy,  32'd0);
        check("scan_stat",     bus.stat,  32'd0);
        check("scan_exp_left", exp_q.size(), 32'd0);

        // Slow ADC: REQ held for 7 cycles, then abort in second V SETTLE.
        push_sweep(12'd3, 12'd4, 12'd9, 12'd2, 12'd1, 1'b0, 32'd140);
        smp_q.push_back(12'd6);
        e.h = 32'd120;
        e.v = 32'd100;
        exp_q.push_back(e);
        ack_delay = 7;
        pulse_start();
        wait_stat(3'd2, 20, "slow_reach_sample");
        for (int i = 0; i < 7; i++) begin
            check("slow_adc_req", bus.adc_req, 32'd1);
            check("slow_stat",    bus.stat,    32'd2);
            check("slow_pos_h",   bus.pos_h,   32'd100);
            check("slow_pos_v",   bus.pos_v,   32'd140);
            @(negedge clk);
        end
        ack_delay = 0;
        n = 0;
        while (!(txn_cnt == 16 && bus.stat == 3'd1) && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("abort_in_settle", bus.stat, 32'd1);
        d0 = done_cnt;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check("abort_stat",    bus.stat,    32'd0);
        check("abort_adc_req", bus.adc_req, 32'd0);
        check("abort_busy",    bus.busy,    32'd0);
        check("abort_pos_h",   bus.pos_h,   32'd120);
        check("abort_pos_v",   bus.pos_v,   32'd110);
        check("abort_max_v",   bus.max_v,   32'd9);
        repeat (4) @(negedge clk);
        check("abort_no_done", done_cnt, d0);
        check("abort_stat_hold", bus.stat, 32'd0);

        // Stray ACK in IDLE is ignored.
        t0 = txn_cnt;
        idle_ack_cnt++;
        repeat (4) @(negedge clk);
        check("idle_ack_seen",  idle_ack_done, 32'd1);
        check("idle_ack_stat",  bus.stat,  32'd0);
        check("idle_ack_txn",   txn_cnt,   t0);
        check("idle_ack_pos_h", bus.pos_h, 32'd120);
        check("idle_ack_pos_v", bus.pos_v, 32'd110);
        check("idle_ack_max_v", bus.max_v, 32'd9);

        // Asynchronous reset between edges while REQ is pending.
        ack_delay = 20;
        pulse_start();
        wait_stat(3'd2, 20, "rst_reach_sample");
        check("pre_rst_adc_req", bus.adc_req, 32'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_adc_req", bus.adc_req, 32'd0);
        check("arst_stat",    bus.stat,    32'd0);
        check("arst_busy",    bus.busy,    32'd0);
        check("arst_done",    bus.done,    32'd0);
        check("arst_pos_h",   bus.pos_h,   32'd120);
        check("arst_pos_v",   bus.pos_v,   32'd120);
        check("arst_max_v",   bus.max_v,   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        ack_delay = 0;
        repeat (3) @(negedge clk);
        check("post_rst_stat", bus.stat, 32'd0);
        check("post_rst_txn",  txn_cnt,  t0);
        check("smp_left",      smp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sp_scan_sequencer.md
SP_SCAN_SEQUENCER -- requirements
Module: sp_scan_sequencer

Interface
REQ-001 Parameter POS_MIN, default 100000, SHALL be the lowest servo pulse width in clock cycles.
REQ-002 Parameter POS_MAX, default 200000, SHALL be the highest servo pulse width.
REQ-003 Parameter POS_STEP, default 10000, SHALL be the sweep increment, which must be greater than 0.
REQ-004 Parameter POS_RST, default 150000, SHALL be the reset position of both axes, within POS_MIN..POS_MAX.
REQ-005 Parameter SETTLE_CYCLES, default 2000000, SHALL be the servo settle wait in clock cycles, which must be at least 1.
REQ-006 CLK  in  1  SHALL be the single clock, with all logic on its rising edge.
REQ-007 RST_N  in  1  SHALL be the reset, asynchronous and active-low.
REQ-008 START  in  1  SHALL be the request to begin a scan, sampled in IDLE only.
REQ-009 ABORT  in  1  SHALL be a synchronous cancel, valid in any state.
REQ-010 ADC_REQ  out  1  SHALL be the ADC conversion request.
REQ-011 ADC_ACK  in  1  SHALL be the ADC handshake acknowledge; ADC_DATA is valid in the same cycle.
REQ-012 ADC_DATA  in  12  SHALL be the panel voltage sample.
REQ-013 POS_H / POS_V  out  32 each  SHALL be the servo pulse-width commands for the horizontal and vertical axes.
REQ-014 MAX_V  out  12  SHALL be the best sample of the most recent axis sweep.
REQ-015 BUSY  out  1  SHALL be high in every state except IDLE.
REQ-016 DONE  out  1  SHALL be a one-cycle pulse at completion of a scan.
REQ-017 STAT  out  3  SHALL carry the state encoding: IDLE=0, SETTLE=1, SAMPLE=2, EVAL=3, PARK=4, FIN=5.

Function
REQ-018 In IDLE, START=1 SHALL perform all of the following and enter SETTLE:
- axis := H
- POS_H := POS_MIN
- best := 0
- best_pos := POS_MIN
- timer := SETTLE_CYCLES
REQ-019 SETTLE SHALL last exactly SETTLE_CYCLES cycles, then enter SAMPLE with ADC_REQ registered high.
REQ-020 In SAMPLE, ADC_REQ SHALL hold high until ADC_ACK=1. On that edge the block SHALL capture ADC_DATA, drop ADC_REQ and enter EVAL.
REQ-021 ADC_ACK outside SAMPLE SHALL be ignored.
REQ-022 EVAL SHALL update best and best_pos when the sample is strictly greater than best; ties keep the earliest position.
REQ-023 EVAL SHALL compute the next position in 33 bits.
- If pos + POS_STEP <= POS_MAX: the active axis position advances by POS_STEP and the block enters SETTLE.
- Otherwise: the block enters PARK.
REQ-024 On entry to PARK, the active axis position SHALL be set to best_pos, MAX_V := best, and a SETTLE_CYCLES wait SHALL run.
REQ-025 At the end of the PARK wait with axis=H, the block SHALL set axis := V, POS_V := POS_MIN, best := 0, best_pos := POS_MIN, and enter SETTLE.
REQ-026 At the end of the PARK wait with axis=V, the block SHALL enter FIN.
REQ-027 FIN SHALL assert DONE for one cycle and then return to IDLE.
REQ-028 The inactive axis position SHALL never change during a sweep.
REQ-029 ABORT=1 SHALL, on the next edge:
- force IDLE
- drop ADC_REQ
- hold POS_H, POS_V and MAX_V unchanged
- not pulse DONE.
ABORT SHALL take priority over every other event.
REQ-030 START while BUSY=1 SHALL be ignored.
REQ-031 With POS_MIN = POS_MAX, each axis SHALL take exactly one sample.

Reset
REQ-032 RST_N=0 SHALL immediately force the following:
- state IDLE
- POS_H = POS_V = POS_RST
- MAX_V = 0, best = 0
- ADC_REQ = 0, BUSY = 0, DONE = 0, STAT = 0
- timer = 0.
REQ-033 Reset during SAMPLE SHALL drop ADC_REQ asynchronously, without waiting for CLK.
REQ-034 After release, the block SHALL act only on the first START seen in IDLE.

Structure
REQ-035 The state encoding, the axis constants H=0 / V=1 and the default timing constants SHALL live in the shared package sp_pkg.
REQ-036 The settle countdown SHALL be the sub-module sp_settle_timer, with load, count and expire behaviour and a 32-bit counter.
REQ-037 The FSM, the best/best_pos registers and the position registers SHALL reside in sp_scan_sequencer.

Verification
All scenarios use POS_MIN=100, POS_MAX=140, POS_STEP=10, POS_RST=120, SETTLE_CYCLES=3 and an ADC model acking one cycle after REQ.
REQ-038 Reset, then 5 idle cycles -> POS_H=POS_V=120, MAX_V=0, STAT=0, BUSY=0, ADC_REQ=0.
REQ-039 Full scan:
- Stimulus: START; H samples 5,9,30,30,2, then V samples 40,1,1,1,50.
- Required response: POS_H parks at 120 (tie keeps earliest), POS_V=140, MAX_V=50, exactly 10 REQ/ACK transactions, one DONE pulse, BUSY low afterwards.
- Timing: exactly 3 cycles in each SETTLE.
REQ-040 ACK delayed 7 cycles -> ADC_REQ stays high for all 7, STAT stays 2, positions unchanged.
REQ-041 ABORT in the second V SETTLE -> STAT=0 next cycle, ADC_REQ=0, no DONE, POS_H=120, POS_V=110 held.
REQ-042 START while busy and ACK pulse in IDLE -> no effect on state, positions or transaction count.
REQ-043 RST_N low mid-SAMPLE, between clock edges -> ADC_REQ=0 immediately, all outputs at their reset values.
